// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU controller definitions: opcode width, IR field layout, fetch defaults, opcode constants.
// Latency: none (constants only).
// Backpressure: none (constants only).
package cpu_ctrl_pkg;

    // Instruction word layout, MSB first: {opCode[4:0], D, operand[PC_W-1:0]}
    localparam int OPC_W = 5;

    // Defaults for the fetch stage
    localparam int          PC_W_DEF      = 8;
    localparam logic [7:0]  RESET_VEC_DEF = 8'h00;

    // Opcodes shared with the Controller
    localparam logic [OPC_W-1:0] OP_MOVLA = 5'b00000;
    localparam logic [OPC_W-1:0] OP_JZ    = 5'b10110;

    // Full instruction width for a given program counter width
    function automatic int ir_width(input int pc_w);
        return OPC_W + 1 + pc_w;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with stack pointer, full/empty flags and a sticky misuse flag.
// Latency: push/pop take effect at the clock edge; top/flags reflect the new state the next cycle.
// Backpressure: none; push-when-full and pop-when-empty are dropped and set err.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    // sp counts entries; low bits address the next free slot, wrapping to 0 when full
    assign wr_idx = sp[AW-1:0];
    assign rd_idx = wr_idx - 1'b1;
    assign top    = mem[rd_idx];
    assign empty  = (sp == '0);
    assign full   = (sp == SP_W'(DEPTH));

    // Stack pointer and sticky error; a push in the same cycle as a pop wins and the pop is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp  <= '0;
            err <= 1'b0;
        end else if (push) begin
            if (full) err <= 1'b1;
            else      sp  <= sp + 1'b1;
        end else if (pop) begin
            if (empty) err <= 1'b1;
            else       sp  <= sp - 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_idx] <= din;
    end

endmodule

// File: rtl/pc_ir_fetch.sv
// Fetch stage: program counter plus instruction register split into opCode/D/operand; optional return stack (RET_STACK_EN).
// Latency: PC and IR fields update one cycle after the strobe edge; all outputs are register bits.
// Backpressure: none; strobes are level enables acted on once per cycle, CALL > RET > LOAD > INC > hold.
module pc_ir_fetch
    import cpu_ctrl_pkg::*;
#(
    parameter int              PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_VEC   = PC_W'(RESET_VEC_DEF),
    parameter int              STACK_DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    Reset_in,
    input  logic                    PC_INC,
    input  logic                    PC_LOAD,
    input  logic                    IR_WR_CLK,
    input  logic [OPC_W+PC_W:0]     instr_in,
    output logic [PC_W-1:0]         PC,
    output logic [OPC_W-1:0]        opCode,
    output logic                    D,
    output logic [PC_W-1:0]         operand,
    output logic                    ir_valid
`ifdef RET_STACK_EN
    ,
    input  logic                    CALL_PUSH,
    input  logic                    RET_POP,
    output logic                    stack_empty,
    output logic                    stack_full,
    output logic                    stack_err
`endif
);

    localparam int IR_W = ir_width(PC_W);

    if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_ir_fetch: STACK_DEPTH must be a power of two and at least 2");
    end

    logic [IR_W-1:0] ir;
    logic [PC_W-1:0] pc_nxt;

    assign opCode  = ir[PC_W+OPC_W:PC_W+1];
    assign D       = ir[PC_W];
    assign operand = ir[PC_W-1:0];

`ifdef RET_STACK_EN
    logic [PC_W-1:0] stk_top;

    // PC pushed here is already past the CALL instruction
    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk   (CLK),
        .rst_n (Reset_in),
        .push  (CALL_PUSH),
        .pop   (RET_POP),
        .din   (PC),
        .top   (stk_top),
        .empty (stack_empty),
        .full  (stack_full),
        .err   (stack_err)
    );
`endif

    // Next-PC priority mux; jump targets use the operand held before this edge
    always_comb begin
        pc_nxt = PC;
`ifdef RET_STACK_EN
        if (CALL_PUSH) begin
            pc_nxt = operand;
        end else if (RET_POP) begin
            if (!stack_empty) pc_nxt = stk_top;
        end else
`endif
        if (PC_LOAD) begin
            pc_nxt = operand;
        end else if (PC_INC) begin
            pc_nxt = PC + 1'b1;
        end
    end

    // Program counter register
    always_ff @(posedge CLK or negedge Reset_in) begin
        if (!Reset_in) PC <= RESET_VEC;
        else           PC <= pc_nxt;
    end

    // Instruction register; ir_valid stays set from the first capture until reset
    always_ff @(posedge CLK or negedge Reset_in) begin
        if (!Reset_in) begin
            ir       <= '0;
            ir_valid <= 1'b0;
        end else if (IR_WR_CLK) begin
            ir       <= instr_in;
            ir_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_ir_fetch.sv
// Self-checking bench for pc_ir_fetch: vector table, reset and stack sequences, random run against a reference model.
// Build with RET_STACK_EN defined to cover the return stack; default build covers PC/IR only.
// Outputs are sampled 1 time unit after the rising edge, or mid-cycle around reset.
module tb_pc_ir_fetch;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        pc_inc;
    logic        pc_load;
    logic        ir_wr;
    logic [13:0] instr;
    logic [7:0]  pc;
    logic [4:0]  opc;
    logic        d_bit;
    logic [7:0]  opnd;
    logic        ir_valid;
    logic        call_push;
    logic        ret_pop;
    logic        s_empty;
    logic        s_full;
    logic        s_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_pc;
    logic [4:0] m_opc;
    logic       m_d;
    logic [7:0] m_opnd;
    logic       m_valid;
    logic       m_err;
    logic [7:0] m_stk [$];

    typedef struct {
        logic        inc;
        logic        load;
        logic        irwr;
        logic [13:0] ins;
        logic [7:0]  e_pc;
        logic [4:0]  e_opc;
        logic        e_d;
        logic [7:0]  e_opnd;
        logic        e_vld;
    } vec_t;

    vec_t tbl [$];

    pc_ir_fetch dut (
        .CLK         (clk),
        .Reset_in    (rst_n),
        .PC_INC      (pc_inc),
        .PC_LOAD     (pc_load),
        .IR_WR_CLK   (ir_wr),
        .instr_in    (instr),
        .PC          (pc),
        .opCode      (opc),
        .D           (d_bit),
        .operand     (opnd),
        .ir_valid    (ir_valid)
`ifdef RET_STACK_EN
        ,
        .CALL_PUSH   (call_push),
        .RET_POP     (ret_pop),
        .stack_empty (s_empty),
        .stack_full  (s_full),
        .stack_err   (s_err)
`endif
    );

`ifndef RET_STACK_EN
    assign s_empty = 1'b1;
    assign s_full  = 1'b0;
    assign s_err   = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 8'h00;
        m_opc   = 5'd0;
        m_d     = 1'b0;
        m_opnd  = 8'h00;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_stk.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
        chk({tag, ".opc"}, 32'(opc), 32'(m_opc));
        chk({tag, ".d"}, 32'(d_bit), 32'(m_d));
        chk({tag, ".operand"}, 32'(opnd), 32'(m_opnd));
        chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(m_valid));
`ifdef RET_STACK_EN
        chk({tag, ".empty"}, 32'(s_empty), 32'(m_stk.size() == 0));
        chk({tag, ".full"}, 32'(s_full), 32'(m_stk.size() == DEPTH));
        chk({tag, ".err"}, 32'(s_err), 32'(m_err));
`endif
    endtask

    // Drive one cycle of strobes, clock it, and advance the model by the specified rules
    task automatic step(input logic inc, input logic load, input logic irwr, input logic [13:0] ins,
                        input logic call, input logic pop);
        pc_inc  = inc;
        pc_load = load;
        ir_wr   = irwr;
        instr   = ins;
`ifdef RET_STACK_EN
        call_push = call;
        ret_pop   = pop;
`else
        call_push = 1'b0;
        ret_pop   = 1'b0;
`endif
        @(posedge clk);
        if (call_push) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_pc);
            else                      m_err = 1'b1;
            m_pc = m_opnd;
        end else if (ret_pop) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_err = 1'b1;
        end else if (load) begin
            m_pc = m_opnd;
        end else if (inc) begin
            m_pc = 8'((int'(m_pc) + 1) % 256);
        end
        if (irwr) begin
            m_opc   = ins[13:9];
            m_d     = ins[8];
            m_opnd  = ins[7:0];
            m_valid = 1'b1;
        end
        #1;
    endtask

    // Assert reset between clock edges and require cleared outputs before the next edge
    task automatic mid_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        chk({tag, ".pc"}, 32'(pc), 32'h00);
        chk({tag, ".opc"}, 32'(opc), 32'h00);
        chk({tag, ".operand"}, 32'(opnd), 32'h00);
        chk({tag, ".ir_valid"}, 32'(ir_valid), 32'h0);
`ifdef RET_STACK_EN
        chk({tag, ".empty"}, 32'(s_empty), 32'h1);
        chk({tag, ".err"}, 32'(s_err), 32'h0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        ir_wr     = 1'b0;
        instr     = '0;
        call_push = 1'b0;
        ret_pop   = 1'b0;
        model_reset();

        // inc, load, irwr, instr, expected pc, opCode, D, operand, ir_valid
        tbl.push_back('{1'b1, 1'b0, 1'b0, 14'h0000, 8'h01, 5'h00, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 14'h0000, 8'h02, 5'h00, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 14'h0000, 8'h03, 5'h00, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 14'h0000, 8'h04, 5'h00, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 14'h0000, 8'h05, 5'h00, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, {5'b00111, 1'b0, 8'h2A}, 8'h06, 5'b00111, 1'b0, 8'h2A, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b1, {5'b10110, 1'b1, 8'h40}, 8'h07, 5'b10110, 1'b1, 8'h40, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, {5'b00001, 1'b0, 8'hFF}, 8'h40, 5'b00001, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 14'h0000, 8'hFF, 5'b00001, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 14'h0000, 8'h00, 5'b00001, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 14'h0000, 8'h01, 5'b00001, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 14'h0000, 8'h02, 5'b00001, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 14'h0000, 8'h03, 5'b00001, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 14'h3FFF, 8'h03, 5'b00001, 1'b0, 8'hFF, 1'b1});

        #12;
        chk("reset.pc", 32'(pc), 32'h00);
        chk("reset.opc", 32'(opc), 32'h00);
        chk("reset.d", 32'(d_bit), 32'h0);
        chk("reset.operand", 32'(opnd), 32'h00);
        chk("reset.ir_valid", 32'(ir_valid), 32'h0);
`ifdef RET_STACK_EN
        chk("reset.empty", 32'(s_empty), 32'h1);
        chk("reset.full", 32'(s_full), 32'h0);
        chk("reset.err", 32'(s_err), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].inc, tbl[i].load, tbl[i].irwr, tbl[i].ins, 1'b0, 1'b0);
            chk($sformatf("vec%0d.pc", i), 32'(pc), 32'(tbl[i].e_pc));
            chk($sformatf("vec%0d.opc", i), 32'(opc), 32'(tbl[i].e_opc));
            chk($sformatf("vec%0d.d", i), 32'(d_bit), 32'(tbl[i].e_d));
            chk($sformatf("vec%0d.operand", i), 32'(opnd), 32'(tbl[i].e_opnd));
            chk($sformatf("vec%0d.ir_valid", i), 32'(ir_valid), 32'(tbl[i].e_vld));
        end

        // Reset in the middle of a cycle after state has been built up
        mid_reset("midreset");

`ifdef RET_STACK_EN
        // Fill, overflow, drain, underflow
        step(1'b0, 1'b0, 1'b1, 14'h0010, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 14'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 14'h0080, 1'b0, 1'b0);
        chk("stk.setup_pc", 32'(pc), 32'h10);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b1, 1'b0);
        chk("stk.call1_pc", 32'(pc), 32'h80);
        chk("stk.call1_empty", 32'(s_empty), 32'h0);
        step(1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b1, 1'b0);
        chk("stk.call4_full", 32'(s_full), 32'h1);
        chk("stk.call4_err", 32'(s_err), 32'h0);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b1, 1'b0);
        chk("stk.call5_err", 32'(s_err), 32'h1);
        chk("stk.call5_pc", 32'(pc), 32'h80);
        chk("stk.call5_full", 32'(s_full), 32'h1);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b1);
        chk("stk.ret1_pc", 32'(pc), 32'h83);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b1);
        chk("stk.ret2_pc", 32'(pc), 32'h82);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b1);
        chk("stk.ret3_pc", 32'(pc), 32'h81);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b1);
        chk("stk.ret4_pc", 32'(pc), 32'h10);
        chk("stk.ret4_empty", 32'(s_empty), 32'h1);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b1);
        chk("stk.ret5_pc", 32'(pc), 32'h10);
        chk("stk.ret5_err", 32'(s_err), 32'h1);
        check_all("stk.model");

        // CALL and RET together: push only, error flag untouched
        mid_reset("stkreset");
        step(1'b0, 1'b0, 1'b1, 14'h0055, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b1, 1'b1);
        chk("both.pc", 32'(pc), 32'h55);
        chk("both.empty", 32'(s_empty), 32'h0);
        chk("both.err", 32'(s_err), 32'h0);
        step(1'b0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b1);
        chk("both.ret_pc", 32'(pc), 32'h00);
        chk("both.ret_empty", 32'(s_empty), 32'h1);
`endif

        // Random strobes against the reference model, with occasional mid-cycle resets
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 14'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0));
            check_all($sformatf("rnd%0d", i));
            if ($urandom_range(0, 99) == 0) mid_reset($sformatf("rndreset%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
